// File: rtl/poseidon_audio_out.sv
// poseidon_audio_out: stereo sample sink that drives an I2S transmitter and a
// pair of first-order 1-bit sigma-delta DACs from the same active sample pair.
//   clk_sys, reset         : single clock, async active-high reset
//   left, right,
//   sample_valid/ready     : one-entry holding register, transfer on valid&ready
//   underrun               : 1-cycle pulse when a frame starts with no new pair
//   I2S_BCK/LRCK/DATA      : I2S master outputs, LRCK=0 is left, one-BCK delay
//   AUDIO_L, AUDIO_R       : sigma-delta bitstreams, density = u / 2^AW
module poseidon_audio_out #(
  parameter int AW        = 16,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4,
  parameter int SIGNED_IN = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] left,
  input  logic [AW-1:0] right,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          underrun,
  output logic          I2S_BCK,
  output logic          I2S_LRCK,
  output logic          I2S_DATA,
  output logic          AUDIO_L,
  output logic          AUDIO_R
);

  localparam int PW = 8;
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [AW-1:0] MSB_MASK = {1'b1, {(AW-1){1'b0}}};
  // Raw value whose offset-binary form is unsigned midscale.
  localparam logic [AW-1:0] MID_RAW  = (SIGNED_IN != 0) ? '0 : MSB_MASK;
  localparam logic [AW-1:0] CONV     = (SIGNED_IN != 0) ? MSB_MASK : '0;

  logic [PW-1:0] presc;
  logic [BW-1:0] bitcnt;
  logic          full;
  logic [AW-1:0] hold_l, hold_r;
  logic [AW-1:0] act_l, act_r;
  logic [AW:0]   acc_l, acc_r;

  logic          tick, fall, slot_wrap, frame_start, transfer;
  logic [BW-1:0] nxt_bitcnt;
  logic          nxt_lrck, nxt_data;
  logic [AW-1:0] ser_word;
  logic [AW-1:0] u_l, u_r;

  assign sample_ready = ~full;
  assign AUDIO_L      = acc_l[AW];
  assign AUDIO_R      = acc_r[AW];

  assign tick        = (presc == PW'(CLK_DIV - 1));
  assign fall        = tick & I2S_BCK;
  assign slot_wrap   = (bitcnt == BW'(SLOT_BITS - 1));
  assign frame_start = fall & slot_wrap & I2S_LRCK;
  assign transfer    = sample_valid & ~full;
  assign nxt_bitcnt  = slot_wrap ? '0 : bitcnt + 1'b1;
  assign nxt_lrck    = slot_wrap ? ~I2S_LRCK : I2S_LRCK;
  assign u_l         = act_l ^ CONV;
  assign u_r         = act_r ^ CONV;

  // Slot position n carries sample bit AW-n for n=1..AW, zero elsewhere.
  always_comb begin
    ser_word = nxt_lrck ? act_r : act_l;
    nxt_data = 1'b0;
    for (int unsigned i = 0; i < AW; i++) begin
      if (nxt_bitcnt == BW'(AW - i)) nxt_data = ser_word[i];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      bitcnt   <= BW'(SLOT_BITS - 1);
      I2S_BCK  <= 1'b0;
      I2S_LRCK <= 1'b1;
      I2S_DATA <= 1'b0;
      underrun <= 1'b0;
      full     <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      act_l    <= MID_RAW;
      act_r    <= MID_RAW;
      acc_l    <= '0;
      acc_r    <= '0;
    end else begin
      if (tick) begin
        presc   <= '0;
        I2S_BCK <= ~I2S_BCK;
      end else begin
        presc   <= presc + 1'b1;
      end

      if (fall) begin
        bitcnt   <= nxt_bitcnt;
        I2S_LRCK <= nxt_lrck;
        I2S_DATA <= nxt_data;
      end

      underrun <= frame_start & ~full;

      if (frame_start && full) begin
        act_l <= hold_l;
        act_r <= hold_r;
        full  <= 1'b0;
      end

      // A transfer on the load edge lands after the load, so it stays held.
      if (transfer) begin
        hold_l <= left;
        hold_r <= right;
        full   <= 1'b1;
      end

      acc_l <= {1'b0, acc_l[AW-1:0]} + {1'b0, u_l};
      acc_r <= {1'b0, acc_r[AW-1:0]} + {1'b0, u_r};
    end
  end

endmodule

// File: tb/tb_poseidon_audio_out.sv
// Bench for poseidon_audio_out: three instances (defaults; AW=8 unsigned;
// CLK_DIV=1 unsigned). I2S slots and frame-start underrun of instance 0/2
// are checked by a scoreboard monitor; density counts are checked directly.
module tb_poseidon_audio_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, v0, rdy0, ur0, bck0, lr0, d0, al0, ar0;
  logic [15:0] l0, r0;
  logic        rst1, v1, rdy1, ur1, bck1, lr1, d1, al1, ar1;
  logic [7:0]  l1, r1;
  logic        rst2, v2, rdy2, ur2, bck2, lr2, d2, al2, ar2;
  logic [15:0] l2, r2;

  poseidon_audio_out dut0 (
    .clk_sys(clk), .reset(rst0), .left(l0), .right(r0), .sample_valid(v0),
    .sample_ready(rdy0), .underrun(ur0), .I2S_BCK(bck0), .I2S_LRCK(lr0),
    .I2S_DATA(d0), .AUDIO_L(al0), .AUDIO_R(ar0)
  );

  poseidon_audio_out #(.AW(8), .SLOT_BITS(16), .CLK_DIV(2), .SIGNED_IN(0)) dut1 (
    .clk_sys(clk), .reset(rst1), .left(l1), .right(r1), .sample_valid(v1),
    .sample_ready(rdy1), .underrun(ur1), .I2S_BCK(bck1), .I2S_LRCK(lr1),
    .I2S_DATA(d1), .AUDIO_L(al1), .AUDIO_R(ar1)
  );

  poseidon_audio_out #(.AW(16), .SLOT_BITS(32), .CLK_DIV(1), .SIGNED_IN(0)) dut2 (
    .clk_sys(clk), .reset(rst2), .left(l2), .right(r2), .sample_valid(v2),
    .sample_ready(rdy2), .underrun(ur2), .I2S_BCK(bck2), .I2S_LRCK(lr2),
    .I2S_DATA(d2), .AUDIO_L(al2), .AUDIO_R(ar2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected slot words and frame-start underrun values
  logic [31:0] exp_slot[$];
  logic        exp_ur[$];

  function automatic logic [31:0] slotw(input logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  task automatic push_frame(input logic u, input logic [15:0] l, input logic [15:0] r);
    exp_ur.push_back(u);
    exp_slot.push_back(slotw(l));
    exp_slot.push_back(slotw(r));
  endtask

  // Monitor watches instance 0 or 2 (same AW/SLOT_BITS)
  logic sel = 1'b0;
  logic m_rst, m_bck, m_lrck, m_data, m_ur;
  assign m_rst  = sel ? rst2 : rst0;
  assign m_bck  = sel ? bck2 : bck0;
  assign m_lrck = sel ? lr2  : lr0;
  assign m_data = sel ? d2   : d0;
  assign m_ur   = sel ? ur2  : ur0;

  logic        pb, pl, ins, fs;
  logic [31:0] sh;

  always @(negedge clk) begin
    if (m_rst) begin
      pb = 1'b0; pl = 1'b1; ins = 1'b0; sh = '0;
    end else begin
      fs = pb && !m_bck && (m_lrck != pl) && !m_lrck;
      if (pb && !m_bck) begin
        if (m_lrck != pl) begin
          if (ins && exp_slot.size() > 0) check("i2s_slot", sh, exp_slot.pop_front());
          sh  = '0;
          ins = 1'b1;
          if (fs && exp_ur.size() > 0) check("underrun_at_frame", {31'b0, m_ur}, {31'b0, exp_ur.pop_front()});
        end
        sh = {sh[30:0], m_data};
      end
      if (!fs && m_ur) check("underrun_stray", {31'b0, m_ur}, 32'd0);
      pb = m_bck;
      pl = m_lrck;
    end
  end

  function automatic logic lr_of(input int d);
    case (d)
      0:       return lr0;
      1:       return lr1;
      default: return lr2;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic offer(input int d, input logic [15:0] l, input logic [15:0] r);
    bit ok;
    ok = 1'b0;
    case (d)
      0:       begin v0 = 1'b1; l0 = l; r0 = r; end
      1:       begin v1 = 1'b1; l1 = l[7:0]; r1 = r[7:0]; end
      default: begin v2 = 1'b1; l2 = l; r2 = r; end
    endcase
    for (int i = 0; i < 3000; i++) begin
      if (rdy_of(d)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    check("offer_accepted", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_frame(input int d, output int n);
    logic prev, cur;
    prev = lr_of(d);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      cur = lr_of(d);
      if (prev && !cur) begin n = i; break; end
      prev = cur;
    end
    if (n < 0) begin
      tests++; fails++;
      $display("FAIL frame_start_timeout: dut %0d got no LRCK fall, required one within 3000 cycles", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_slot.size() + exp_ur.size()) > 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_slot.size() + exp_ur.size(), 32'd0);
  endtask

  task automatic density(output int cl, output int cr);
    cl = 0; cr = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (al1) cl++;
      if (ar1) cr++;
    end
  endtask

  logic [15:0] p_l [5] = '{16'h0F0F, 16'h1234, 16'hA5A5, 16'hFFFF, 16'h0001};
  logic [15:0] p_r [5] = '{16'hF0F0, 16'h5678, 16'h5A5A, 16'h0000, 16'h8000};

  initial begin
    int n, idx, fseen, rdy_hi, ntx, cl, cr;
    bit done, adv;
    logic lrp;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0; l2 = '0; r2 = '0;
    #2;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    // Reset values, with valid asserted that must be ignored
    @(negedge clk);
    v0 = 1'b1; l0 = 16'hDEAD; r0 = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("rst_bck",   {31'b0, bck0}, 32'd0);
    check("rst_lrck",  {31'b0, lr0},  32'd1);
    check("rst_data",  {31'b0, d0},   32'd0);
    check("rst_audio", {30'b0, al0, ar0}, 32'd0);
    check("rst_underrun", {31'b0, ur0}, 32'd0);
    check("rst_ready_with_valid", {31'b0, rdy0}, 32'd1);
    check("rst1_outs", {25'b0, bck1, lr1, d1, al1, ar1, ur1, rdy1}, 32'b0100001);
    check("rst2_outs", {25'b0, bck2, lr2, d2, al2, ar2, ur2, rdy2}, 32'b0100001);
    v0 = 1'b0;

    // Pair before first frame, then two underrun frames repeating it
    push_frame(1'b0, 16'h8001, 16'h7FFE);
    push_frame(1'b1, 16'h8001, 16'h7FFE);
    push_frame(1'b1, 16'h8001, 16'h7FFE);
    rst0 = 1'b0;
    offer(0, 16'h8001, 16'h7FFE);
    wait_frame(0, n);
    wait_frame(0, n);
    wait_frame(0, n);

    // sample_valid held high: one transfer per frame
    v0 = 1'b1; l0 = p_l[0]; r0 = p_r[0];
    idx = 0; fseen = 0; rdy_hi = 0; ntx = 0; done = 1'b0; adv = 1'b0; lrp = lr0;
    for (int i = 0; i < 3000; i++) begin
      if (lrp && !lr0) begin
        fseen++;
        if (fseen >= 2) check("ready_cycles_per_frame", rdy_hi, 32'd1);
        rdy_hi = 0;
      end
      lrp = lr0;
      if (rdy0) begin
        rdy_hi++; ntx++;
        push_frame(1'b0, l0, r0);
        adv = 1'b1;
        if (fseen == 3) begin done = 1'b1; break; end
      end
      @(negedge clk);
      if (adv && idx < 3) begin
        idx++; l0 = p_l[idx]; r0 = p_r[idx];
      end
      adv = 1'b0;
    end
    @(negedge clk);
    v0 = 1'b0;
    check("hold_valid_done", {31'b0, done}, 32'd1);
    check("hold_valid_transfers", ntx, 32'd4);

    // Transfer on the very edge of a frame start that finds the register empty
    wait_frame(0, n);
    push_frame(1'b1, p_l[3], p_r[3]);
    push_frame(1'b0, p_l[4], p_r[4]);
    repeat (511) @(negedge clk);
    v0 = 1'b1; l0 = p_l[4]; r0 = p_r[4];
    @(negedge clk);
    v0 = 1'b0;
    check("coincide_lrck_fell", {31'b0, lr0}, 32'd0);
    check("coincide_underrun", {31'b0, ur0}, 32'd1);
    check("coincide_held_full", {31'b0, rdy0}, 32'd0);
    drain();
    rst0 = 1'b1;

    // CLK_DIV=1 instance: reset mid right slot
    @(negedge clk);
    sel = 1'b1;
    exp_ur.push_back(1'b0);
    exp_slot.push_back(slotw(16'h1234));
    @(negedge clk);
    rst2 = 1'b0;
    offer(2, 16'h1234, 16'hABCD);
    wait_frame(2, n);
    for (int i = 0; i < 200 && !lr2; i++) @(negedge clk);
    check("dut2_in_right_slot", {31'b0, lr2}, 32'd1);
    repeat (5) @(negedge clk);
    offer(2, 16'h5555, 16'h6666);
    repeat (10) @(negedge clk);
    #2 rst2 = 1'b1;
    #1;
    check("midrst_outs", {26'b0, bck2, lr2, d2, al2, ar2, ur2}, 32'b010000);
    check("midrst_ready", {31'b0, rdy2}, 32'd1);
    repeat (3) @(negedge clk);
    push_frame(1'b1, 16'h8000, 16'h8000);
    push_frame(1'b1, 16'h8000, 16'h8000);
    rst2 = 1'b0;
    wait_frame(2, n);
    check("post_reset_first_fall_cycles", n, 32'd2);
    drain();
    rst2 = 1'b1;

    // AW=8 unsigned instance: sigma-delta density
    @(negedge clk);
    rst1 = 1'b0;
    offer(1, 16'h0040, 16'h0000);
    wait_frame(1, n);
    repeat (4) @(negedge clk);
    density(cl, cr);
    check("density_L_0x40", cl, 32'd64);
    check("density_R_0x00", cr, 32'd0);
    offer(1, 16'h0000, 16'h00C0);
    wait_frame(1, n);
    repeat (4) @(negedge clk);
    density(cl, cr);
    check("density_L_0x00", cl, 32'd0);
    check("density_R_0xC0", cr, 32'd192);
    rst1 = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2 ms, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
